game_countdown_timer: RTL and testbench

- Game-clock countdown for the basketball system; it is the consumer of the 1 Hz seconds tick.
- It holds a MM:SS value, decrements it once per tick while running, and flags expiry with a timed buzzer pulse.
- Contains its own tick prescaler so it runs on the system clk alone.
- Drives the scoreboard display and the horn logic.

---
 rtl/game_clock_pkg.sv | 15 +
 rtl/game_countdown_timer_tick_prescaler.sv | 28 ++
 rtl/game_countdown_timer.sv | 152 +++++++++++++++
 tb/tb_game_countdown_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_clock_pkg.sv
// Shared types and field widths for the game-clock countdown.
package game_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED,
    EXPIRED
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_W   = 4;
  localparam int SEC_W   = 6;

endpackage

// File: rtl/game_countdown_timer_tick_prescaler.sv
// Free-running divider that pulses tick on the last count of each DIV-cycle period.
module tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_reg;

  assign tick = en && (count_reg == LAST);

  // Holding on en=0 keeps the partial period across a pause.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// MM:SS game-clock countdown with built-in seconds prescaler and expiry buzzer.
// Defining GAME_COUNTDOWN_TENTHS_EN adds a tenths digit and a 10x faster prescaler.
module game_countdown_timer
  import game_clock_pkg::*;
#(
  parameter int TICK_DIV    = 50,
  parameter int BUZZ_CYCLES = 20,
  parameter int MAX_MIN     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             stop,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic             expired,
`ifdef GAME_COUNTDOWN_TENTHS_EN
  output logic [3:0]       tenths,
`endif
  output logic             buzzer
);

`ifdef GAME_COUNTDOWN_TENTHS_EN
  localparam int PRESCALE = TICK_DIV / 10;
`else
  localparam int PRESCALE = TICK_DIV;
`endif
  localparam int BUZZ_W = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam logic [MIN_W-1:0]  MIN_CAP  = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0]  SEC_CAP  = SEC_W'(SEC_MAX);
  localparam logic [BUZZ_W-1:0] BUZZ_LEN = BUZZ_W'(BUZZ_CYCLES);

  state_t            state_reg, state_next;
  logic [MIN_W-1:0]  min_reg, min_next;
  logic [SEC_W-1:0]  sec_reg, sec_next;
  logic [BUZZ_W-1:0] buzz_cnt_reg, buzz_cnt_next;
  logic              running_reg, expired_reg, buzzer_reg;
  logic              tick, clr, value_zero, sec_step, next_zero;
`ifdef GAME_COUNTDOWN_TENTHS_EN
  logic [3:0]        tenths_reg, tenths_next;

  assign value_zero = (min_reg == '0) && (sec_reg == '0) && (tenths_reg == '0);
  assign sec_step   = tick && (tenths_reg == '0);
  assign next_zero  = (min_next == '0) && (sec_next == '0) && (tenths_next == '0);
  assign tenths     = tenths_reg;
`else
  assign value_zero = (min_reg == '0) && (sec_reg == '0);
  assign sec_step   = tick;
  assign next_zero  = (min_next == '0) && (sec_next == '0);
`endif

  tick_prescaler #(.DIV(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (state_reg == RUNNING),
    .tick (tick)
  );

  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    sec_next      = sec_reg;
    buzz_cnt_next = buzz_cnt_reg;
    clr           = 1'b0;
`ifdef GAME_COUNTDOWN_TENTHS_EN
    tenths_next   = tenths_reg;
`endif
    if (buzz_cnt_reg != '0) buzz_cnt_next = buzz_cnt_reg - 1'b1;

    if (load) begin
      state_next    = IDLE;
      min_next      = (load_min > MIN_CAP) ? MIN_CAP : load_min;
      sec_next      = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
      buzz_cnt_next = '0;
      clr           = 1'b1;
`ifdef GAME_COUNTDOWN_TENTHS_EN
      tenths_next   = '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !stop && !value_zero) begin
            state_next = RUNNING;
            clr        = 1'b1;
          end
        end
        RUNNING: begin
`ifdef GAME_COUNTDOWN_TENTHS_EN
          if (tick) tenths_next = (tenths_reg != '0) ? tenths_reg - 1'b1 : 4'd9;
`endif
          if (sec_step) begin
            if (sec_reg != '0) begin
              sec_next = sec_reg - 1'b1;
            end else if (min_reg != '0) begin
              min_next = min_reg - 1'b1;
              sec_next = SEC_CAP;
            end
          end
          // A tick that coincides with stop still counts; reaching zero beats pausing.
          if (tick && next_zero) begin
            state_next    = EXPIRED;
            buzz_cnt_next = BUZZ_LEN;
          end else if (stop) begin
            state_next = PAUSED;
          end
        end
        PAUSED: begin
          if (start && !stop) state_next = RUNNING;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      min_reg      <= MIN_CAP;
      sec_reg      <= '0;
      buzz_cnt_reg <= '0;
      running_reg  <= 1'b0;
      expired_reg  <= 1'b0;
      buzzer_reg   <= 1'b0;
`ifdef GAME_COUNTDOWN_TENTHS_EN
      tenths_reg   <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      sec_reg      <= sec_next;
      buzz_cnt_reg <= buzz_cnt_next;
      running_reg  <= (state_next == RUNNING);
      expired_reg  <= (state_next == EXPIRED);
      buzzer_reg   <= (buzz_cnt_next != '0);
`ifdef GAME_COUNTDOWN_TENTHS_EN
      tenths_reg   <= tenths_next;
`endif
    end
  end

  assign minutes = min_reg;
  assign seconds = sec_reg;
  assign running = running_reg;
  assign expired = expired_reg;
  assign buzzer  = buzzer_reg;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench: single-cycle vector table followed by multi-cycle countdown sequences.
module tb_game_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] minutes;
  logic [5:0] seconds;
  logic       running, expired, buzzer;
`ifdef GAME_COUNTDOWN_TENTHS_EN
  logic [3:0] tenths;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  game_countdown_timer #(.TICK_DIV(50), .BUZZ_CYCLES(20), .MAX_MIN(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .stop     (stop),
    .minutes  (minutes),
    .seconds  (seconds),
    .running  (running),
    .expired  (expired),
`ifdef GAME_COUNTDOWN_TENTHS_EN
    .tenths   (tenths),
`endif
    .buzzer   (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, load, lmin, lsec, start, stop;
    int emin, esec, erun, eexp, ebuzz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input int m, input int s);
    load = 1'b1; load_min = 4'(m); load_sec = 6'(s);
    step();
    load = 1'b0;
    $display("load %0d:%0d -> %0d:%0d running=%0b", m, s, minutes, seconds, running);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int buzz_high;
    //              rst load min sec start stop | min sec run exp buzz
    vecs[0]  = '{1, 0,  0,  0,  0, 0,  12,  0, 0, 0, 0};
    vecs[1]  = '{0, 1,  0,  0,  0, 0,   0,  0, 0, 0, 0};
    vecs[2]  = '{0, 0,  0,  0,  1, 0,   0,  0, 0, 0, 0};
    vecs[3]  = '{0, 1, 15, 63,  0, 0,  12, 59, 0, 0, 0};
    vecs[4]  = '{0, 0,  0,  0,  1, 1,  12, 59, 0, 0, 0};
    vecs[5]  = '{0, 0,  0,  0,  1, 0,  12, 59, 1, 0, 0};
    vecs[6]  = '{0, 0,  0,  0,  0, 1,  12, 59, 0, 0, 0};
    vecs[7]  = '{0, 0,  0,  0,  1, 1,  12, 59, 0, 0, 0};
    vecs[8]  = '{0, 0,  0,  0,  1, 0,  12, 59, 1, 0, 0};
    vecs[9]  = '{0, 1,  7, 30,  1, 0,   7, 30, 0, 0, 0};
    vecs[10] = '{0, 1,  9, 59,  0, 1,   9, 59, 0, 0, 0};
    vecs[11] = '{0, 0,  0,  0,  1, 0,   9, 59, 1, 0, 0};
    vecs[12] = '{1, 1,  3,  3,  1, 0,  12,  0, 0, 0, 0};

    for (int i = 0; i < NV; i++) begin
      rst      = (vecs[i].rst != 0);
      load     = (vecs[i].load != 0);
      load_min = 4'(vecs[i].lmin);
      load_sec = 6'(vecs[i].lsec);
      start    = (vecs[i].start != 0);
      stop     = (vecs[i].stop != 0);
      step();
      $display("vec %0d: min=%0d sec=%0d running=%0b expired=%0b buzzer=%0b",
               i, minutes, seconds, running, expired, buzzer);
      chk($sformatf("vec%0d_min", i), int'(minutes), vecs[i].emin);
      chk($sformatf("vec%0d_sec", i), int'(seconds), vecs[i].esec);
      chk($sformatf("vec%0d_running", i), int'(running), vecs[i].erun);
      chk($sformatf("vec%0d_expired", i), int'(expired), vecs[i].eexp);
      chk($sformatf("vec%0d_buzzer", i), int'(buzzer), vecs[i].ebuzz);
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;

    // 0:02 to expiry, buzzer length, no retrigger
    do_load(0, 2);
    do_start();
    chk("t1_running_after_start", int'(running), 1);
    steps(49);
    chk("t1_sec_at_49", int'(seconds), 2);
    step();
    $display("t1 cycle 50: sec=%0d", seconds);
    chk("t1_sec_at_50", int'(seconds), 1);
    steps(49);
    chk("t1_sec_at_99", int'(seconds), 1);
    chk("t1_running_at_99", int'(running), 1);
    step();
    $display("t1 cycle 100: sec=%0d expired=%0b buzzer=%0b", seconds, expired, buzzer);
    chk("t1_sec_at_100", int'(seconds), 0);
    chk("t1_expired_at_100", int'(expired), 1);
    chk("t1_running_at_100", int'(running), 0);
    chk("t1_buzzer_at_100", int'(buzzer), 1);
    buzz_high = buzzer ? 1 : 0;
    for (int k = 0; k < 40 && buzzer; k++) begin
      step();
      if (buzzer) buzz_high++;
    end
    $display("t1 buzzer high cycles=%0d", buzz_high);
    chk("t1_buzzer_len", buzz_high, 20);
    steps(5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_no_retrigger", int'(buzzer), 0);
    chk("t1_expired_holds", int'(expired), 1);
    chk("t1_start_ignored", int'(running), 0);
    chk("t1_min_zero", int'(minutes), 0);

    // 1:00 minute borrow
    do_load(1, 0);
    do_start();
    steps(50);
    $display("t2: %0d:%0d running=%0b", minutes, seconds, running);
    chk("t2_min", int'(minutes), 0);
    chk("t2_sec", int'(seconds), 59);
    chk("t2_running", int'(running), 1);

    // pause keeps the partial prescaler count
    do_load(0, 5);
    do_start();
    steps(29);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_paused", int'(running), 0);
    steps(49);
    do_start();
    chk("t3_resumed", int'(running), 1);
    steps(19);
    chk("t3_sec_at_99", int'(seconds), 5);
    step();
    $display("t3 cycle 100: sec=%0d", seconds);
    chk("t3_sec_at_100", int'(seconds), 4);

    // reset while running
    do_load(3, 30);
    do_start();
    steps(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("t4 after rst: %0d:%0d running=%0b", minutes, seconds, running);
    chk("t4_min", int'(minutes), 12);
    chk("t4_sec", int'(seconds), 0);
    chk("t4_running", int'(running), 0);
    chk("t4_expired", int'(expired), 0);

    // load during active buzzer, start held across the load
    do_load(0, 1);
    do_start();
    steps(50);
    chk("t5_expired", int'(expired), 1);
    chk("t5_buzzer_on", int'(buzzer), 1);
    steps(3);
    load = 1'b1; load_min = 4'd0; load_sec = 6'd10; start = 1'b1;
    step();
    load = 1'b0;
    $display("t5 after load: %0d:%0d buzzer=%0b running=%0b", minutes, seconds, buzzer, running);
    chk("t5_buzzer_off", int'(buzzer), 0);
    chk("t5_expired_off", int'(expired), 0);
    chk("t5_idle", int'(running), 0);
    chk("t5_sec", int'(seconds), 10);
    step();
    start = 1'b0;
    chk("t5_start_after_load", int'(running), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
